// File: rtl/key_event_gen.sv
// Turns debounced key levels into single-cycle press/release/long/repeat events
// for three keys sharing one free-running millisecond tick.
module key_event_gen #(
  parameter int unsigned TICK_DIV  = 48_000,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned REPEAT_MS = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key_flag,
  output logic [2:0] key_press,
  output logic [2:0] key_release,
  output logic [2:0] key_long,
  output logic [2:0] key_repeat,
  output logic [2:0] key_held,
  output logic [2:0] key_long_held
);

  localparam int unsigned NKEY   = 3;
  localparam int unsigned TICK_W = 32;
  localparam int unsigned CNT_W  = 16;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  LONG_LAST = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0]  REP_LAST  = CNT_W'(REPEAT_MS - 1);
  localparam logic              REP_EN    = (REPEAT_MS != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_LONG = 2'd2
  } state_e;

  logic [NKEY-1:0]   s1_q, s2_q, s3_q;
  logic [NKEY-1:0]   rise_c, fall_c;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick_c;

  state_e            state_q [NKEY];
  logic [CNT_W-1:0]  cnt_q   [NKEY];
  logic [NKEY-1:0]   press_q, release_q, long_q, repeat_q, long_held_q;

  // Two-flop synchronizer plus a history flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= key_flag;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_c = s2_q & ~s3_q;
  assign fall_c = ~s2_q & s3_q;

  // Free-running ms tick; never realigned to key activity
  assign tick_c     = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // Per-key event FSM; release wins over a same-cycle tick
  always_ff @(posedge clk) begin
    if (rst) begin
      press_q     <= '0;
      release_q   <= '0;
      long_q      <= '0;
      repeat_q    <= '0;
      long_held_q <= '0;
      for (int k = 0; k < NKEY; k++) begin
        state_q[k] <= ST_IDLE;
        cnt_q[k]   <= '0;
      end
    end else begin
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      repeat_q  <= '0;
      for (int k = 0; k < NKEY; k++) begin
        case (state_q[k])
          ST_IDLE: begin
            if (rise_c[k]) begin
              press_q[k] <= 1'b1;
              cnt_q[k]   <= '0;
              state_q[k] <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (fall_c[k]) begin
              release_q[k] <= 1'b1;
              cnt_q[k]     <= '0;
              state_q[k]   <= ST_IDLE;
            end else if (tick_c) begin
              if (cnt_q[k] == LONG_LAST) begin
                long_q[k]      <= 1'b1;
                long_held_q[k] <= 1'b1;
                cnt_q[k]       <= '0;
                state_q[k]     <= ST_LONG;
              end else begin
                cnt_q[k] <= cnt_q[k] + CNT_W'(1);
              end
            end
          end
          ST_LONG: begin
            if (fall_c[k]) begin
              release_q[k]   <= 1'b1;
              long_held_q[k] <= 1'b0;
              cnt_q[k]       <= '0;
              state_q[k]     <= ST_IDLE;
            end else if (tick_c && REP_EN) begin
              if (cnt_q[k] == REP_LAST) begin
                repeat_q[k] <= 1'b1;
                cnt_q[k]    <= '0;
              end else begin
                cnt_q[k] <= cnt_q[k] + CNT_W'(1);
              end
            end
          end
          default: begin
            long_held_q[k] <= 1'b0;
            cnt_q[k]       <= '0;
            state_q[k]     <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign key_press     = press_q;
  assign key_release   = release_q;
  assign key_long      = long_q;
  assign key_repeat    = repeat_q;
  assign key_held      = s2_q;
  assign key_long_held = long_held_q;

endmodule

// File: tb/tb_key_event_gen.sv
// Scoreboard bench for key_event_gen: one instance with repeat enabled, one
// with repeat disabled, both driven by the same key levels.
module tb_key_event_gen;

  typedef struct {
    int          cyc;
    logic [17:0] a;
    logic [17:0] z;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] key_flag;
  logic       done = 1'b0;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  logic [2:0] press_a, rel_a, long_a, rep_a, held_a, lheld_a;
  logic [2:0] press_z, rel_z, long_z, rep_z, held_z, lheld_z;
  logic [17:0] obs_a, obs_z;

  ev_t evq[$];
  ev_t lvq[$];

  key_event_gen #(.TICK_DIV(10), .LONG_MS(5), .REPEAT_MS(3)) u_dut (
    .clk(clk), .rst(rst), .key_flag(key_flag),
    .key_press(press_a), .key_release(rel_a), .key_long(long_a),
    .key_repeat(rep_a), .key_held(held_a), .key_long_held(lheld_a)
  );

  key_event_gen #(.TICK_DIV(10), .LONG_MS(5), .REPEAT_MS(0)) u_dut_norep (
    .clk(clk), .rst(rst), .key_flag(key_flag),
    .key_press(press_z), .key_release(rel_z), .key_long(long_z),
    .key_repeat(rep_z), .key_held(held_z), .key_long_held(lheld_z)
  );

  assign obs_a = {press_a, rel_a, long_a, rep_a, held_a, lheld_a};
  assign obs_z = {press_z, rel_z, long_z, rep_z, held_z, lheld_z};

  always #5 clk = ~clk;

  // Cycle index since the last edge that sampled rst high
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [17:0] ob(input logic [2:0] p, input logic [2:0] r,
                                     input logic [2:0] l, input logic [2:0] rp,
                                     input logic [2:0] h, input logic [2:0] lh);
    return {p, r, l, rp, h, lh};
  endfunction

  task automatic push_ev(input int c, input logic [17:0] a, input logic [17:0] z);
    ev_t e;
    e.cyc = c; e.a = a; e.z = z;
    evq.push_back(e);
  endtask

  task automatic push_lv(input int c, input logic [17:0] a, input logic [17:0] z);
    ev_t e;
    e.cyc = c; e.a = a; e.z = z;
    lvq.push_back(e);
  endtask

  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc=%0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops an expected event whenever any pulse output is high
  always @(negedge clk) begin
    ev_t e;
    if (obs_a[17:6] != 12'd0 || obs_z[17:6] != 12'd0) begin
      if (evq.size() == 0) begin
        cmp("unexpected_pulse", {14'd0, obs_a[17:0]}, 32'd0);
        cmp("unexpected_pulse_norep", {14'd0, obs_z[17:0]}, 32'd0);
      end else begin
        e = evq.pop_front();
        cmp("event_cycle", 32'(cyc), 32'(e.cyc));
        cmp("event_outputs", {14'd0, obs_a}, {14'd0, e.a});
        cmp("event_outputs_norep", {14'd0, obs_z}, {14'd0, e.z});
      end
    end
    if (lvq.size() != 0 && lvq[0].cyc == cyc) begin
      e = lvq.pop_front();
      cmp("level_outputs", {14'd0, obs_a}, {14'd0, e.a});
      cmp("level_outputs_norep", {14'd0, obs_z}, {14'd0, e.z});
    end
    if (done) begin
      cmp("events_outstanding", 32'(evq.size()), 32'd0);
      cmp("levels_outstanding", 32'(lvq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [17:0] zero;
    zero = '0;
    rst = 1'b1;
    key_flag = 3'b000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset
    push_lv(100, zero, zero);

    // Short press on key 0
    at(100);
    key_flag[0] = 1'b1;
    push_lv(112, ob(3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000),
                 ob(3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000));
    push_ev(103, ob(3'b001, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000),
                 ob(3'b001, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000));
    push_ev(123, ob(3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000),
                 ob(3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000));
    at(120);
    key_flag[0] = 1'b0;

    // Long press with repeats on key 1
    at(200);
    key_flag[1] = 1'b1;
    push_ev(203, ob(3'b010, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000),
                 ob(3'b010, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000));
    push_ev(250, ob(3'b000, 3'b000, 3'b010, 3'b000, 3'b010, 3'b010),
                 ob(3'b000, 3'b000, 3'b010, 3'b000, 3'b010, 3'b010));
    push_lv(260, ob(3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010),
                 ob(3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010));
    push_ev(280, ob(3'b000, 3'b000, 3'b000, 3'b010, 3'b010, 3'b010),
                 ob(3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010));
    push_ev(310, ob(3'b000, 3'b000, 3'b000, 3'b010, 3'b010, 3'b010),
                 ob(3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010));
    push_ev(323, ob(3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000),
                 ob(3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000));
    at(320);
    key_flag[1] = 1'b0;

    // Key 2 fall lands on the tick that would have fired long
    at(400);
    key_flag[2] = 1'b1;
    push_ev(403, ob(3'b100, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000),
                 ob(3'b100, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000));
    push_ev(450, ob(3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000),
                 ob(3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000));
    push_lv(460, zero, zero);
    at(447);
    key_flag[2] = 1'b0;

    // All keys together, then reset while in LONG
    at(500);
    key_flag = 3'b111;
    push_ev(503, ob(3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 3'b000),
                 ob(3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 3'b000));
    push_ev(550, ob(3'b000, 3'b000, 3'b111, 3'b000, 3'b111, 3'b111),
                 ob(3'b000, 3'b000, 3'b111, 3'b000, 3'b111, 3'b111));
    push_ev(580, ob(3'b000, 3'b000, 3'b000, 3'b111, 3'b111, 3'b111),
                 ob(3'b000, 3'b000, 3'b000, 3'b000, 3'b111, 3'b111));
    at(590);
    push_lv(0, zero, zero);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Keys still high after reset: fresh press, long, repeats only on repeat-enabled DUT
    push_ev(3, ob(3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 3'b000),
               ob(3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 3'b000));
    push_ev(50, ob(3'b000, 3'b000, 3'b111, 3'b000, 3'b111, 3'b111),
                ob(3'b000, 3'b000, 3'b111, 3'b000, 3'b111, 3'b111));
    for (int i = 0; i < 5; i++) begin
      push_ev(80 + 30 * i, ob(3'b000, 3'b000, 3'b000, 3'b111, 3'b111, 3'b111),
                           ob(3'b000, 3'b000, 3'b000, 3'b000, 3'b111, 3'b111));
    end
    push_ev(203, ob(3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000),
                 ob(3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000));
    at(200);
    key_flag = 3'b000;

    at(260);
    done = 1'b1;
  end

endmodule
